// File: rtl/case_mux_pkg.sv
// Shared types and helpers for the case_mux_seq slice.
package case_mux_pkg;

    localparam int OOR_CNT_W = 8;
    localparam int SEL_MAX_W = 8;

    // Widest select code the slice supports; narrower selects are zero-extended into it.
    typedef logic [SEL_MAX_W-1:0] sel_code_t;

    function automatic logic sel_in_range(input sel_code_t sel, input int num_in);
        return int'(sel) < num_in;
    endfunction

endpackage

// File: rtl/case_mux_out_reg.sv
// Valid/ready output register: captures whenever empty or being drained, otherwise stalls.
module case_mux_out_reg #(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic              o_cap,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid
);

    assign o_cap = !o_valid || i_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_data  <= '0;
            o_valid <= 1'b0;
        end else if (o_cap) begin
            o_data  <= i_data;
            o_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/case_mux_seq.sv
// Registered N-input case mux with select sequencer and valid/ready output.
// Optional CASE_MUX_OOR_FLAG_EN adds sel_oor and a saturating oor_count.
module case_mux_seq
    import case_mux_pkg::*;
#(
    parameter int NUM_IN = 3,
    parameter int DATA_W = 1,
    parameter int SEL_W  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic                     sel_load,
    input  logic [SEL_W-1:0]         sel_in,
    input  logic                     step,
    input  logic                     auto_en,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEL_W-1:0]         sel_cur
`ifdef CASE_MUX_OOR_FLAG_EN
    ,
    output logic                     sel_oor,
    output logic [OOR_CNT_W-1:0]     oor_count
`endif
);

    logic [SEL_W-1:0]  r_sel;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] w_ch [NUM_IN];
    logic [DATA_W-1:0] w_mux;
    logic              w_in_range;
    logic              w_cap;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_ch
        assign w_ch[k] = in_data[k*DATA_W +: DATA_W];
    end

    assign w_in_range = sel_in_range(sel_code_t'(r_sel), NUM_IN);

    // Out-of-range codes replay the last in-range sample rather than leaving a latch path.
    always_comb begin
        w_mux = r_hold;
        for (int k = 0; k < NUM_IN; k++) begin
            if (r_sel == SEL_W'(k)) w_mux = w_ch[k];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel  <= '0;
            r_hold <= '0;
        end else begin
            if (w_cap && w_in_range) r_hold <= w_mux;
            // Load wins over advance; advance wraps through the out-of-range codes too.
            if (sel_load)
                r_sel <= sel_in;
            else if (w_cap && (auto_en || step))
                r_sel <= r_sel + SEL_W'(1);
        end
    end

    case_mux_out_reg #(.DATA_W(DATA_W)) u_out (
        .clk     (clk),
        .reset   (reset),
        .i_data  (w_mux),
        .i_ready (out_ready),
        .o_cap   (w_cap),
        .o_data  (out_data),
        .o_valid (out_valid)
    );

    assign sel_cur = r_sel;

`ifdef CASE_MUX_OOR_FLAG_EN
    logic                 r_oor;
    logic [OOR_CNT_W-1:0] r_oor_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_oor     <= 1'b0;
            r_oor_cnt <= '0;
        end else if (w_cap) begin
            r_oor <= !w_in_range;
            if (!w_in_range && r_oor_cnt != '1) r_oor_cnt <= r_oor_cnt + 1'b1;
        end
    end

    assign sel_oor   = r_oor;
    assign oor_count = r_oor_cnt;
`endif

endmodule

// File: tb/tb_case_mux_seq.sv
// Directed bench for case_mux_seq: three instances cover 1-bit, 8-bit and wide-select configs.
module tb_case_mux_seq;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    // u_a / u_c: free-running auto sequence; u_b: directed control
    logic        ac_auto, ac_ready;
    logic [2:0]  a_in;
    logic [0:0]  a_out;
    logic        a_valid;
    logic [1:0]  a_sel;

    logic [39:0] c_in;
    logic [7:0]  c_out;
    logic        c_valid;
    logic [2:0]  c_sel;

    logic [23:0] b_in;
    logic        b_load, b_step, b_auto, b_ready;
    logic [1:0]  b_sel_in;
    logic [7:0]  b_out;
    logic        b_valid;
    logic [1:0]  b_sel;

`ifdef CASE_MUX_OOR_FLAG_EN
    logic       a_oor, b_oor, c_oor;
    logic [7:0] a_cnt, b_cnt, c_cnt;
`endif

    case_mux_seq #(.NUM_IN(3), .DATA_W(1), .SEL_W(2)) u_a (
        .clk(clk), .reset(reset), .in_data(a_in), .sel_load(1'b0), .sel_in(2'd0),
        .step(1'b0), .auto_en(ac_auto), .out_data(a_out), .out_valid(a_valid),
        .out_ready(ac_ready), .sel_cur(a_sel)
`ifdef CASE_MUX_OOR_FLAG_EN
        , .sel_oor(a_oor), .oor_count(a_cnt)
`endif
    );

    case_mux_seq #(.NUM_IN(3), .DATA_W(8), .SEL_W(2)) u_b (
        .clk(clk), .reset(reset), .in_data(b_in), .sel_load(b_load), .sel_in(b_sel_in),
        .step(b_step), .auto_en(b_auto), .out_data(b_out), .out_valid(b_valid),
        .out_ready(b_ready), .sel_cur(b_sel)
`ifdef CASE_MUX_OOR_FLAG_EN
        , .sel_oor(b_oor), .oor_count(b_cnt)
`endif
    );

    case_mux_seq #(.NUM_IN(5), .DATA_W(8), .SEL_W(3)) u_c (
        .clk(clk), .reset(reset), .in_data(c_in), .sel_load(1'b0), .sel_in(3'd0),
        .step(1'b0), .auto_en(ac_auto), .out_data(c_out), .out_valid(c_valid),
        .out_ready(ac_ready), .sel_cur(c_sel)
`ifdef CASE_MUX_OOR_FLAG_EN
        , .sel_oor(c_oor), .oor_count(c_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge; reset is released well before the next edge.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    logic [0:0] exp_a [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] exp_c [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h14, 8'h14, 8'h14};

    initial begin
        a_in = 3'b101;
        c_in = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
        b_in = 24'h332211;
        ac_auto = 1'b1; ac_ready = 1'b1;
        b_load = 1'b0; b_step = 1'b0; b_auto = 1'b0; b_ready = 1'b1; b_sel_in = 2'd0;

        #1 reset = 1'b1;
        #1;
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_data",  32'(a_out),   32'd0);
        chk("rst_sel",   32'(c_sel),   32'd0);
        #1 reset = 1'b0;

        // auto sequence (u_a) and wrap through out-of-range codes (u_c)
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("auto_a_data", 32'(a_out), 32'(exp_a[(i-1) % 4]));
            chk("auto_a_valid", 32'(a_valid), 32'd1);
            chk("wrap_c_data", 32'(c_out), 32'(exp_c[(i-1) % 8]));
            chk("wrap_c_sel",  32'(c_sel), 32'(i % 8));
        end
`ifdef CASE_MUX_OOR_FLAG_EN
        chk("wrap_c_oorcnt", 32'(c_cnt), 32'd3);
`endif
        ac_auto = 1'b0;

        // out-of-range hold: load 2 then 3
        do_reset();
        b_load = 1'b1; b_sel_in = 2'd2;
        tick();
        chk("oor_first", 32'(b_out), 32'h11);
        b_sel_in = 2'd3;
        tick();
        chk("oor_ch2", 32'(b_out), 32'h33);
        chk("oor_sel3", 32'(b_sel), 32'd3);
`ifdef CASE_MUX_OOR_FLAG_EN
        chk("oor_flag0", 32'(b_oor), 32'd0);
`endif
        b_load = 1'b0;
        tick();
        chk("oor_hold", 32'(b_out), 32'h33);
`ifdef CASE_MUX_OOR_FLAG_EN
        chk("oor_flag1", 32'(b_oor), 32'd1);
        chk("oor_cnt1",  32'(b_cnt), 32'd1);
`endif

        // backpressure: freeze for 4 cycles, then resume without skipping a code
        do_reset();
        b_auto = 1'b1;
        tick();
        chk("bp_first", 32'(b_out), 32'h11);
        b_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold_data", 32'(b_out), 32'h11);
            chk("bp_hold_sel",  32'(b_sel), 32'd1);
            chk("bp_hold_vld",  32'(b_valid), 32'd1);
        end
        b_ready = 1'b1;
        tick();
        chk("bp_rel1", 32'(b_out), 32'h22);
        chk("bp_sel2", 32'(b_sel), 32'd2);
        tick();
        chk("bp_rel2", 32'(b_out), 32'h33);

        // load beats advance; capture uses the old select
        do_reset();
        b_auto = 1'b0;
        b_load = 1'b1; b_sel_in = 2'd1; b_step = 1'b1;
        tick();
        chk("lva_data", 32'(b_out), 32'h11);
        chk("lva_sel",  32'(b_sel), 32'd1);
        b_load = 1'b0; b_step = 1'b0;
        tick();
        chk("lva_next", 32'(b_out), 32'h22);
        chk("lva_nostep", 32'(b_sel), 32'd1);
        b_step = 1'b1;
        tick();
        chk("step_sel", 32'(b_sel), 32'd2);
        b_step = 1'b0;

        // step while stalled is dropped
        b_ready = 1'b0;
        tick();
        b_step = 1'b1;
        tick();
        b_step = 1'b0;
        chk("stall_step_sel", 32'(b_sel), 32'd2);

        // async reset mid-stall, checked before any further clock edge
        tick();
        chk("pre_rst_vld", 32'(b_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_vld",  32'(b_valid), 32'd0);
        chk("async_sel",  32'(b_sel),   32'd0);
        chk("async_data", 32'(b_out),   32'd0);
        reset = 1'b0;
        b_ready = 1'b1;
        tick();
        chk("post_rst_ch0", 32'(b_out), 32'h11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/case_mux_seq.md
Name: case_mux_seq

Overview:
- Parametrised, registered N-input case multiplexer with an internal select sequencer and a valid/ready output stage.
- Generalises the 3-input, 2-bit-select combinational mux to NUM_IN channels of DATA_W bits.
- Out-of-range select codes are handled with an explicit registered hold, never an inferred latch.
- Sits between free-running stimulus or sensor inputs and a downstream consumer that may apply backpressure.

Parameters:
- NUM_IN, 3, number of input channels; 2 <= NUM_IN <= 2**SEL_W.
- DATA_W, 1, width of each channel.
- SEL_W, 2, select width; codes >= NUM_IN are out-of-range.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- in_data  in  NUM_IN*DATA_W  packed channels; channel k at bits [k*DATA_W +: DATA_W]
- sel_load  in  1  load sel_in into the select register
- sel_in  in  SEL_W  select value for load
- step  in  1  single-shot select advance request
- auto_en  in  1  advance select after every accepted sample
- out_data  out  DATA_W  registered mux output
- out_valid  out  1  out_data holds an unconsumed sample
- out_ready  in  1  consumer accepts out_data
- sel_cur  out  SEL_W  current select register

Behaviour:
- Clocking and reset: clock clk; reset is asynchronous, active-high. All state resets on posedge reset.
- Reset values: sel_cur=0, out_data=0, out_valid=0, hold register=0.
- Capture enable: cap = !out_valid || out_ready, evaluated every cycle.
- On cap:
  - in-range code (sel_cur < NUM_IN): out_data <= channel[sel_cur] and hold <= the same value.
  - out-of-range code: out_data <= hold, i.e. the last in-range value; hold is unchanged.
  - out_valid <= 1.
- Not cap: out_data and out_valid are stable (stall). No sample is lost or duplicated to the consumer.
- Latency: 1 cycle from sel_cur and in_data to out_data.
- Select update priority: sel_load > advance > hold.
  - sel_load: sel_cur <= sel_in, regardless of cap.
  - advance happens when cap && (auto_en || step) && !sel_load.
  - Advance is sel_cur+1 modulo 2**SEL_W. Wrap covers out-of-range codes deliberately.
  - A step asserted while stalled is dropped (single-cycle semantics); it is not queued.
- Simultaneous events:
  - sel_load with cap: the capture uses the OLD sel_cur; the new select applies from the next cycle.
- Reset mid-stall: out_valid drops to 0 immediately; a pending sample is discarded.
- After reset release, the first capture occurs on the first clk edge and produces channel 0.

Optional Feature:
- Macro: CASE_MUX_OOR_FLAG_EN.
- Defined:
  - adds output port sel_oor (1 bit), registered alongside out_data; it is 1 when the captured sample came from an out-of-range code.
  - adds output oor_count (8 bits): saturating count of out-of-range captures, cleared by reset.
- Undefined: neither port exists and the behaviour is otherwise identical.

Decomposition:
- Package case_mux_pkg holds:
  - function sel_in_range(sel, num_in);
  - localparam OOR_CNT_W = 8;
  - a typedef for the select code.
- Sub-module case_mux_out_reg: the valid/ready output register with the stall logic, parametrised by DATA_W.
- The top holds the select sequencer, the hold register and the case decode.

Test Plan:
- Reset and auto-sequence: NUM_IN=3, DATA_W=1, in_data=3'b101, auto_en=1, out_ready=1.
  - -> out_data sequence 1,0,1,1 (code 3 holds 1), repeating.
  - -> out_valid=1 from the first edge after reset.
- Out-of-range hold: DATA_W=8, channels {0x33,0x22,0x11}; sel_load sel_in=2 then sel_in=3.
  - -> out_data=0x33, then 0x33 again.
  - -> with the flag macro: sel_oor=0 then 1, oor_count=1.
- Backpressure: out_ready=0 for 4 cycles with auto_en=1.
  - -> out_data and sel_cur frozen.
  - -> on release, the next sample is from sel_cur+1 and no code is skipped.
- Load vs advance: sel_load=1, sel_in=1, step=1 in the same cycle with sel_cur=0.
  - -> capture uses code 0; sel_cur=1 next cycle (no advance to 2).
- Async reset mid-stall: assert reset between clk edges while out_valid=1, out_ready=0.
  - -> out_valid=0, sel_cur=0, out_data=0 immediately, without waiting for clk.
- Wrap: SEL_W=3, NUM_IN=5, auto_en=1.
  - -> sel_cur runs 0..7 then 0.
  - -> codes 5, 6, 7 output channel 4's value.
